// File: rtl/ram_2p_arbiter.sv
// ram_2p_arbiter: round-robin sharing of one true dual-port RAM between NUM_REQ requesters
module ram_2p_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int RAM_DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*RAM_DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [NUM_REQ*RAM_DATA_WIDTH-1:0]   rsp_data,
  output logic                                ram_ena,
  output logic                                ram_wea,
  output logic [RAM_ADDR_WIDTH-1:0]           ram_addra,
  output logic [RAM_DATA_WIDTH-1:0]           ram_dina,
  input  logic [RAM_DATA_WIDTH-1:0]           ram_douta,
  output logic                                ram_enb,
  output logic                                ram_web,
  output logic [RAM_ADDR_WIDTH-1:0]           ram_addrb,
  output logic [RAM_DATA_WIDTH-1:0]           ram_dinb,
  input  logic [RAM_DATA_WIDTH-1:0]           ram_doutb
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int AW    = RAM_ADDR_WIDTH;
  localparam int DW    = RAM_DATA_WIDTH;

  logic [AW-1:0]    addr  [NUM_REQ];
  logic [DW-1:0]    wdata [NUM_REQ];
  logic [IDX_W-1:0] rr_ptr, a_idx, b_idx, cand, tag_a, tag_b;
  logic             a_ok, b_ok, a_go, b_go, rd_a, rd_b;

  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr[i]  = req_addr[i*AW +: AW];
    assign wdata[i] = req_wdata[i*DW +: DW];
  end

  // Scan from rr_ptr: first valid takes port A, next compatible valid takes port B
  always_comb begin
    a_ok  = 1'b0;
    b_ok  = 1'b0;
    a_idx = '0;
    b_idx = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap(int'(rr_ptr) + k);
      if (!a_ok && req_valid[cand]) begin
        a_ok  = 1'b1;
        a_idx = cand;
      end else if (a_ok && !b_ok && req_valid[cand] &&
                   ((addr[cand] != addr[a_idx]) || (!req_we[cand] && !req_we[a_idx]))) begin
        b_ok  = 1'b1;
        b_idx = cand;
      end
    end
  end

  assign a_go      = a_ok && !rst;
  assign b_go      = b_ok && !rst;
  assign ram_ena   = a_go;
  assign ram_wea   = a_go && req_we[a_idx];
  assign ram_addra = a_go ? addr[a_idx] : '0;
  assign ram_dina  = a_go ? wdata[a_idx] : '0;
  assign ram_enb   = b_go;
  assign ram_web   = b_go && req_we[b_idx];
  assign ram_addrb = b_go ? addr[b_idx] : '0;
  assign ram_dinb  = b_go ? wdata[b_idx] : '0;

  // Grant vector: one bit per issued port
  always_comb begin
    req_ready = '0;
    if (a_go) req_ready[a_idx] = 1'b1;
    if (b_go) req_ready[b_idx] = 1'b1;
  end

  // Round-robin pointer moves past the last granted requester; read tags follow the RAM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      rd_a   <= 1'b0;
      rd_b   <= 1'b0;
      tag_a  <= '0;
      tag_b  <= '0;
    end else begin
      if (a_go) rr_ptr <= wrap(int'(b_go ? b_idx : a_idx) + 1);
      rd_a  <= a_go && !req_we[a_idx];
      rd_b  <= b_go && !req_we[b_idx];
      tag_a <= a_idx;
      tag_b <= b_idx;
    end
  end

  // Steer each port's read data to the requester that issued it; idle lanes read zero
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_valid[k]         = (rd_a && tag_a == IDX_W'(k)) || (rd_b && tag_b == IDX_W'(k));
      rsp_data[k*DW +: DW] = (rd_a && tag_a == IDX_W'(k)) ? ram_douta :
                             (rd_b && tag_b == IDX_W'(k)) ? ram_doutb : '0;
    end
  end
endmodule

// File: tb/tb_ram_2p_arbiter.sv
// tb_ram_2p_arbiter: random and directed checks against a queue-based arbitration model
module tb_ram_2p_arbiter;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] v = '0;
  logic [NR-1:0] we = '0;
  logic [AW-1:0] ad [NR];
  logic [DW-1:0] wd [NR];
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0] req_ready, rsp_valid;
  logic [NR*DW-1:0] rsp_data;
  logic ram_ena, ram_wea, ram_enb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  bit mem_init = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int rr = 0;
  logic [NR-1:0] exp_rv = '0;
  logic [NR*DW-1:0] exp_rd = '0;
  logic [NR-1:0] obs_ready, obs_rv;
  logic [NR*DW-1:0] obs_rd;

  ram_2p_arbiter #(.NUM_REQ(NR), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_ready(req_ready), .req_we(we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_douta(ram_douta), .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb),
    .ram_dinb(ram_dinb), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = ad[i];
      req_wdata[i*DW +: DW] = wd[i];
    end
  end

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i * 3 + 1);
      mem_init <= 1'b1;
    end else begin
      if (ram_ena) begin
        ram_douta <= mem[ram_addra];
        if (ram_wea) mem[ram_addra] <= ram_dina;
      end
      if (ram_enb) begin
        ram_doutb <= mem[ram_addrb];
        if (ram_web) mem[ram_addrb] <= ram_dinb;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit compat(input int x, input int y);
    return (ad[x] != ad[y]) || (!we[x] && !we[y]);
  endfunction

  task automatic model_grant(output int ga, output int gb);
    int order[$];
    ga = -1;
    gb = -1;
    if (rst) return;
    for (int k = 0; k < NR; k++) if (v[(rr + k) % NR]) order.push_back((rr + k) % NR);
    if (order.size() > 0) ga = order[0];
    for (int j = 1; j < order.size(); j++) if (gb < 0 && compat(order[j], ga)) gb = order[j];
  endtask

  task automatic step();
    int ga, gb;
    logic [NR-1:0] er, nrv;
    logic [NR*DW-1:0] nrd;
    logic [AW+DW+1:0] ea, eb;
    #1;
    if (rst) begin
      exp_rv = '0;
      exp_rd = '0;
      rr = 0;
    end
    model_grant(ga, gb);
    er = '0;
    if (ga >= 0) er[ga] = 1'b1;
    if (gb >= 0) er[gb] = 1'b1;
    ea = (ga >= 0) ? {1'b1, we[ga], ad[ga], wd[ga]} : '0;
    eb = (gb >= 0) ? {1'b1, we[gb], ad[gb], wd[gb]} : '0;
    check("ready", req_ready, er);
    check("rsp_valid", rsp_valid, exp_rv);
    check("rsp_data", rsp_data, exp_rd);
    check("port_a", {ram_ena, ram_wea, ram_addra, ram_dina}, ea);
    check("port_b", {ram_enb, ram_web, ram_addrb, ram_dinb}, eb);
    obs_ready = req_ready;
    obs_rv = rsp_valid;
    obs_rd = rsp_data;
    @(posedge clk);
    if (!rst) begin
      nrv = '0;
      nrd = '0;
      if (ga >= 0 && !we[ga]) begin nrv[ga] = 1'b1; nrd[ga*DW +: DW] = ref_mem[ad[ga]]; end
      if (gb >= 0 && !we[gb]) begin nrv[gb] = 1'b1; nrd[gb*DW +: DW] = ref_mem[ad[gb]]; end
      if (ga >= 0 && we[ga]) ref_mem[ad[ga]] = wd[ga];
      if (gb >= 0 && we[gb]) ref_mem[ad[gb]] = wd[gb];
      rr = (gb >= 0) ? (gb + 1) % NR : (ga >= 0) ? (ga + 1) % NR : rr;
      exp_rv = nrv;
      exp_rd = nrd;
    end
    @(negedge clk);
  endtask

  task automatic req(input int i, input bit w, input int a, input int d);
    v[i] = 1'b1;
    we[i] = w;
    ad[i] = AW'(a);
    wd[i] = DW'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int got;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i * 3 + 1);
    for (int i = 0; i < NR; i++) begin ad[i] = '0; wd[i] = '0; end
    @(negedge clk);
    step();
    v = '1;
    step();
    check("rst_ready", obs_ready, 0);
    check("rst_rsp", obs_rv, 0);
    rst = 1'b0;
    v = '0;
    step();
    check("idle_ready", obs_ready, 0);
    req(0, 1, 5, 'h11);
    step();
    check("t1_wr_ready", obs_ready, 4'b0001);
    v = '0;
    req(0, 0, 5, 0);
    step();
    v = '0;
    step();
    check("t1_rsp_valid", obs_rv, 4'b0001);
    check("t1_rsp_data", obs_rd[31:0], 'h11);
    do_reset();
    for (int i = 0; i < NR; i++) req(i, 0, 20 + i, 0);
    step();
    check("t2_g0", obs_ready, 4'b0011);
    step();
    check("t2_g1", obs_ready, 4'b1100);
    check("t2_rsp0", obs_rv, 4'b0011);
    step();
    check("t2_g2", obs_ready, 4'b0011);
    check("t2_rsp1", obs_rv, 4'b1100);
    v = '0;
    step();
    do_reset();
    req(0, 0, 1, 0);
    step();
    v = '0;
    req(1, 1, 7, 'hAA);
    req(2, 1, 7, 'hBB);
    step();
    check("t3_first", obs_ready, 4'b0010);
    v[1] = 1'b0;
    step();
    check("t3_second", obs_ready, 4'b0100);
    v = '0;
    req(0, 0, 7, 0);
    step();
    v = '0;
    step();
    check("t3_rd7", obs_rd[31:0], 'hBB);
    do_reset();
    req(0, 0, 3, 0);
    req(1, 1, 3, 'h55);
    req(2, 0, 9, 0);
    step();
    check("t4_grant", obs_ready, 4'b0101);
    v[0] = 1'b0;
    v[2] = 1'b0;
    step();
    check("t4_defer", obs_ready, 4'b0010);
    check("t4_rsp", obs_rv, 4'b0101);
    check("t4_old", obs_rd[31:0], 10);
    v = '0;
    req(0, 0, 4, 0);
    req(1, 0, 4, 0);
    step();
    check("t5_grant", obs_ready, 4'b0011);
    v = '0;
    step();
    check("t5_rsp", obs_rv, 4'b0011);
    check("t5_d0", obs_rd[31:0], 13);
    check("t5_d1", obs_rd[63:32], 13);
    req(0, 0, 4, 0);
    step();
    rst = 1'b1;
    v = '1;
    we = '0;
    step();
    check("t6_rst_rsp", obs_rv, 0);
    check("t6_rst_ready", obs_ready, 0);
    rst = 1'b0;
    v = '0;
    step();
    check("t6_dropped", obs_rv, 0);
    for (int i = 0; i < NR; i++) req(i, 0, 30 + i, 0);
    step();
    check("t6_rr0", obs_ready, 4'b0011);
    for (int r = 0; r < 6; r++) begin
      got = 0;
      for (int c = 0; c < NR && got == 0; c++) begin
        for (int i = 0; i < NR; i++) req(i, 1'($urandom), $urandom_range(0, 3), $urandom);
        step();
        if (obs_ready[3]) got = c + 1;
      end
      check("fair3", got > 0, 1);
    end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        v[i] = 1'($urandom);
        we[i] = 1'($urandom);
        ad[i] = AW'($urandom_range(0, 7));
        wd[i] = $urandom;
      end
      step();
    end
    v = '0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
